// File: rtl/spi_reg_bank_pkg.sv
// Shared types and constants for the SPI-slave register bank.
// Header byte layout is {rw, addr}; rw=1 selects a read frame.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam int HDR_BITS = 8;
  localparam int RW_BIT   = 7;

  localparam logic [7:0] DEFAULT_RD = 8'hC3;

  // LSB position of register idx inside a flat NUM_REGS*width bus.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin, with single-clk rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Oversampled SPI mode-0 slave driving a parametrised register bank with burst
// auto-increment, read-only slices fed from ext_rd_data, and per-register strobes.
//
//   state | meaning
//   IDLE  | no frame in progress, miso holds last value (tri-stated while cs0 high)
//   ADDR  | shifting in the 8-bit header {rw, addr}
//   DATA  | one DATA_BITS word per iteration, address advances after each word
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                    NUM_REGS   = 32,
  parameter int                    ADDR_BITS  = 7,
  parameter int                    DATA_BITS  = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = 32'h2,
  parameter logic [DATA_BITS-1:0]  RESET_VAL  = '0,
  parameter logic [7:0]            DEFAULT_RD = spi_reg_pkg::DEFAULT_RD
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          spi_cs0,
  input  logic                          spi_clk,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  input  logic [NUM_REGS*DATA_BITS-1:0] ext_rd_data,
  output logic [NUM_REGS*DATA_BITS-1:0] regs_out,
  output logic [NUM_REGS-1:0]           wr_stb,
  output logic [NUM_REGS-1:0]           rd_stb,
  output logic                          spi_busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]     HDR_LAST  = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0]     WORD_LAST = CNT_W'(DATA_BITS - 1);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_meta_q, mosi_s_q;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (spi_cs0),
    .sync_o  (cs_s),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (spi_clk),
    .sync_o  (sclk_s),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      mosi_meta_q <= spi_mosi;
      mosi_s_q    <= mosi_meta_q;
    end
  end

  state_e state_q, state_d;
  logic   hdr_done, word_done;

  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_in_q, shift_in_d;
  logic [DATA_BITS-1:0] shift_out_q, shift_out_d;
  logic                 skip_q, skip_d;
  logic                 rw_q, rw_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [NUM_REGS-1:0]  wr_stb_q, wr_stb_d;
  logic [NUM_REGS-1:0]  rd_stb_q, rd_stb_d;
  logic [DATA_BITS-1:0] regs_q [NUM_REGS];

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; a frame only starts with the mode-0 clock at idle-low
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cs_fall && !sclk_s) state_d = ST_ADDR;
      ST_ADDR: begin
        if (cs_rise)       state_d = ST_IDLE;
        else if (hdr_done) state_d = ST_DATA;
      end
      ST_DATA: if (cs_rise) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs and frame events
  always_comb begin
    spi_busy  = (state_q != ST_IDLE);
    hdr_done  = (state_q == ST_ADDR) && sclk_rise && (bit_cnt_q == HDR_LAST);
    word_done = (state_q == ST_DATA) && sclk_rise && (bit_cnt_q == WORD_LAST);
  end

  logic [DATA_BITS-1:0] word_in;
  logic [7:0]           hdr_byte;
  logic [ADDR_BITS-1:0] cur_addr, nxt_addr;
  logic [IDX_W-1:0]     idx;
  logic                 in_range, rd_load, wr_ok;
  logic [DATA_BITS-1:0] rd_word;

  assign word_in  = {shift_in_q[DATA_BITS-2:0], mosi_s_q};
  assign hdr_byte = word_in[HDR_BITS-1:0];
  assign cur_addr = hdr_done ? hdr_byte[ADDR_BITS-1:0] : addr_q;
  assign nxt_addr = (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
  assign idx      = cur_addr[IDX_W-1:0];
  assign in_range = (cur_addr <= LAST_ADDR);
  assign rd_load  = (hdr_done && hdr_byte[RW_BIT]) || (word_done && rw_q);
  assign wr_ok    = word_done && !rw_q && in_range && !RO_MASK[idx];

  always_comb begin
    rd_word = {(DATA_BITS / 8){DEFAULT_RD}};
    if (in_range) begin
      if (RO_MASK[idx]) rd_word = ext_rd_data[slice_lsb(int'(idx), DATA_BITS) +: DATA_BITS];
      else              rd_word = regs_q[idx];
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    skip_d      = skip_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wr_stb_d    = '0;
    rd_stb_d    = '0;

    if (state_q == ST_IDLE) begin
      bit_cnt_d = '0;
    end else if (sclk_rise) begin
      shift_in_d = word_in;
      bit_cnt_d  = (hdr_done || word_done) ? '0 : bit_cnt_q + 1'b1;
    end

    if (hdr_done) begin
      rw_d   = hdr_byte[RW_BIT];
      addr_d = hdr_byte[RW_BIT] ? nxt_addr : cur_addr;
    end else if (word_done) begin
      addr_d = nxt_addr;
    end

    if (wr_ok) wr_stb_d[idx] = 1'b1;

    // The loaded MSB is already on miso, so the first falling edge after a load must not shift.
    if (rd_load) begin
      shift_out_d = rd_word;
      skip_d      = 1'b1;
      if (in_range) rd_stb_d[idx] = 1'b1;
    end else if (sclk_fall && state_q != ST_IDLE) begin
      if (skip_q) skip_d      = 1'b0;
      else        shift_out_d = {shift_out_q[DATA_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      skip_q      <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wr_stb_q    <= '0;
      rd_stb_q    <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      skip_q      <= skip_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wr_stb_q    <= wr_stb_d;
      rd_stb_q    <= rd_stb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (wr_ok) begin
      regs_q[idx] <= word_in;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[slice_lsb(g, DATA_BITS) +: DATA_BITS] = RO_MASK[g] ? '0 : regs_q[g];
  end

  assign wr_stb   = wr_stb_q;
  assign rd_stb   = rd_stb_q;
  assign spi_miso = cs_s ? 1'bz : shift_out_q[DATA_BITS-1];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: a table of single-word frames plus hand-written
// burst, aborted-frame and mid-frame reset sequences.
module tb_spi_reg_bank;
  localparam int NR = 32;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spi_cs0 = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_mosi = 1'b0;
  wire  spi_miso;
  logic [NR*DB-1:0] ext_rd_data;
  logic [NR*DB-1:0] regs_out;
  logic [NR-1:0]    wr_stb;
  logic [NR-1:0]    rd_stb;
  logic             spi_busy;

  always #5 clk = ~clk;

  spi_reg_bank dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_cs0     (spi_cs0),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .ext_rd_data (ext_rd_data),
    .regs_out    (regs_out),
    .wr_stb      (wr_stb),
    .rd_stb      (rd_stb),
    .spi_busy    (spi_busy)
  );

  int checks = 0;
  int errors = 0;

  int  wr_cnt[NR] = '{default: 0};
  int  rd_cnt[NR] = '{default: 0};
  int  wr_base[NR];
  int  rd_base[NR];
  int  multi_hot = 0;
  time wr_first = 0;
  logic wr_prev = 1'b0;
  time last_rise = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (wr_stb[i]) wr_cnt[i]++;
      if (rd_stb[i]) rd_cnt[i]++;
    end
    if ($countones(wr_stb) + $countones(rd_stb) > 1) multi_hot++;
    if (|wr_stb && !wr_prev) wr_first = $time;
    wr_prev = |wr_stb;
  end

  logic [7:0] model [NR];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name);
    logic [NR*DB-1:0] exp;
    for (int i = 0; i < NR; i++) exp[i*DB +: DB] = model[i];
    checks++;
    if (regs_out !== exp) begin
      errors++;
      $display("FAIL %s: regs_out %h expected %h", name, regs_out, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < NR; i++) begin
      wr_base[i] = wr_cnt[i];
      rd_base[i] = rd_cnt[i];
    end
  endtask

  function automatic int wr_tot();
    int s = 0;
    for (int i = 0; i < NR; i++) s += wr_cnt[i] - wr_base[i];
    return s;
  endfunction

  function automatic int rd_tot();
    int s = 0;
    for (int i = 0; i < NR; i++) s += rd_cnt[i] - rd_base[i];
    return s;
  endfunction

  task automatic half();
    repeat (10) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int b = 7; b > 7 - nbits; b--) begin
      spi_mosi = tx[b];
      half();
      rx[b] = spi_miso;
      spi_clk = 1'b1;
      last_rise = $time;
      half();
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs0 = 1'b0;
    half();
  endtask

  task automatic cs_high();
    half();
    spi_cs0 = 1'b1;
    half();
  endtask

  task automatic frame(input logic [7:0] hdr, input logic [7:0] dat, output logic [7:0] rx);
    logic [7:0] dummy;
    cs_low();
    xfer(hdr, 8, dummy);
    xfer(dat, 8, rx);
    cs_high();
  endtask

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] dat;
    logic [7:0] exp_rx;
    int         exp_wr;
    int         exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] rx;
    logic [7:0] dummy;
    int a;

    ext_rd_data = '0;
    ext_rd_data[15:8] = 8'h5A;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;

    vecs[0] = '{8'h00, 8'hA5, 8'h00, 1, 0};
    vecs[1] = '{8'h80, 8'h00, 8'hA5, 0, 2};
    vecs[2] = '{8'h81, 8'h00, 8'h5A, 0, 2};
    vecs[3] = '{8'h01, 8'hFF, 8'h00, 0, 0};
    vecs[4] = '{8'hC0, 8'h00, 8'hC3, 0, 0};
    vecs[5] = '{8'h40, 8'h12, 8'h00, 0, 0};
    vecs[6] = '{8'h05, 8'h3C, 8'h00, 1, 0};
    vecs[7] = '{8'h85, 8'h00, 8'h3C, 0, 2};

    repeat (3) @(negedge clk);
    chk("rst_busy", spi_busy, 0);
    chk("rst_miso_z", (spi_miso === 1'bz), 1);
    chk("rst_strobes", {wr_stb, rd_stb}, 0);
    chk_regs("rst_regs");
    reset_n = 1'b1;
    half();

    for (int v = 0; v < 8; v++) begin
      snap();
      frame(vecs[v].hdr, vecs[v].dat, rx);
      a = int'(vecs[v].hdr[6:0]);
      if (!vecs[v].hdr[7] && a < NR && a != 1) model[a] = vecs[v].dat;
      chk($sformatf("v%0d_wr_total", v), wr_tot(), vecs[v].exp_wr);
      chk($sformatf("v%0d_rd_total", v), rd_tot(), vecs[v].exp_rd);
      if (vecs[v].hdr[7]) chk($sformatf("v%0d_miso", v), rx, vecs[v].exp_rx);
      if (vecs[v].exp_wr == 1) begin
        chk($sformatf("v%0d_wr_reg", v), wr_cnt[a] - wr_base[a], 1);
        chk($sformatf("v%0d_wr_latency", v), longint'(wr_first - last_rise), 30);
      end
      if (vecs[v].hdr[7] && a < NR) chk($sformatf("v%0d_rd_reg", v), rd_cnt[a] - rd_base[a], 1);
      chk_regs($sformatf("v%0d_regs", v));
    end

    // burst with wrap from the last register back to 0
    snap();
    cs_low();
    xfer(8'h1E, 8, dummy);
    xfer(8'h11, 8, dummy);
    xfer(8'h22, 8, dummy);
    xfer(8'h33, 8, dummy);
    cs_high();
    model[30] = 8'h11;
    model[31] = 8'h22;
    model[0]  = 8'h33;
    chk("burst_wr_total", wr_tot(), 3);
    chk("burst_wr30", wr_cnt[30] - wr_base[30], 1);
    chk("burst_wr31", wr_cnt[31] - wr_base[31], 1);
    chk("burst_wr0", wr_cnt[0] - wr_base[0], 1);
    chk_regs("burst_regs");

    // partial word aborted by cs0, then a complete frame
    snap();
    cs_low();
    chk("busy_in_frame", spi_busy, 1);
    xfer(8'h02, 8, dummy);
    xfer(8'hAB, 5, dummy);
    cs_high();
    chk("abort_wr_total", wr_tot(), 0);
    chk("abort_busy", spi_busy, 0);
    chk_regs("abort_regs");
    snap();
    frame(8'h02, 8'h66, dummy);
    model[2] = 8'h66;
    chk("after_abort_wr2", wr_cnt[2] - wr_base[2], 1);
    chk_regs("after_abort_regs");

    // reset in the middle of a burst
    cs_low();
    xfer(8'h04, 8, dummy);
    xfer(8'h44, 8, dummy);
    xfer(8'h55, 3, dummy);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    chk("midrst_busy", spi_busy, 0);
    chk("midrst_miso_z", (spi_miso === 1'bz), 1);
    chk_regs("midrst_regs");
    reset_n = 1'b1;
    cs_high();
    snap();
    frame(8'h03, 8'h7E, dummy);
    model[3] = 8'h7E;
    chk("postrst_wr3", wr_cnt[3] - wr_base[3], 1);
    chk_regs("postrst_regs");

    chk("one_hot_strobes", multi_hot, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
